// File: rtl/comparator_pkg.sv
// Shared types for the comparator checker: FSM state, the {eq, gt, lt}
// result bundle and its three legal one-hot codes.
package comparator_pkg;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t CMP_EQ = 3'b100;
  localparam cmp_res_t CMP_GT = 3'b010;
  localparam cmp_res_t CMP_LT = 3'b001;

  // A well-formed comparator response raises exactly one of its three flags
  function automatic logic is_onehot(input cmp_res_t r);
    return (r == CMP_EQ) || (r == CMP_GT) || (r == CMP_LT);
  endfunction

endpackage

// File: rtl/comparator_ref.sv
// Combinational golden model: unsigned compare of a against b.
module comparator_ref
  import comparator_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output cmp_res_t         res_o
);

  // Exactly one flag is set for any operand pair, including WIDTH = 1
  always_comb begin
    res_o.eq = (a_i == b_i);
    res_o.gt = (a_i >  b_i);
    res_o.lt = (a_i <  b_i);
  end

endmodule

// File: rtl/comparator_checker.sv
// Self-checking responder for comparator benches. Stage 1 registers an
// accepted beat, stage 2 compares it against comparator_ref and updates
// saturating pass/fail counters and sticky error flags.
// Optional first-failure capture ports: COMPARATOR_CHECKER_CAPTURE_EN.
module comparator_checker
  import comparator_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int CNT_W        = 16,
  parameter int HALT_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_equal,
  input  logic             in_greater,
  input  logic             in_less,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             onehot_err,
`ifdef COMPARATOR_CHECKER_CAPTURE_EN
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_flags,
`endif
  output logic             halted
);

  state_e           state_q, state_d;
  logic             vld_q;
  logic [WIDTH-1:0] a_q, b_q;
  cmp_res_t         flg_q, exp_res;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic             err_q, oh_err_q;
  logic             accept, beat_pass, beat_fail, beat_bad_oh;

  assign accept = in_valid && in_ready;

  // Stage 1: capture the accepted beat; clear/reset drop anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      flg_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        flg_q <= '{eq: in_equal, gt: in_greater, lt: in_less};
      end
    end
  end

  comparator_ref #(.WIDTH(WIDTH)) u_ref (
    .a_i  (a_q),
    .b_i  (b_q),
    .res_o(exp_res)
  );

  // A non-one-hot response can never equal the reference, so it also fails
  assign beat_pass   = vld_q && (flg_q == exp_res);
  assign beat_fail   = vld_q && (flg_q != exp_res);
  assign beat_bad_oh = vld_q && !is_onehot(flg_q);

  // Stage 2: saturating counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pass_q   <= '0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      oh_err_q <= 1'b0;
    end else begin
      if (beat_pass && (pass_q != '1)) pass_q <= pass_q + CNT_W'(1);
      if (beat_fail && (fail_q != '1)) fail_q <= fail_q + CNT_W'(1);
      if (beat_fail)   err_q    <= 1'b1;
      if (beat_bad_oh) oh_err_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state and handshake; clear wins over a failure in the same cycle
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = !clear;
        if (beat_fail && (HALT_ON_FAIL != 0)) state_d = ST_HALT;
      end
      ST_HALT: in_ready = 1'b0;
      default: state_d = ST_RUN;
    endcase
    if (clear) state_d = ST_RUN;
  end

`ifdef COMPARATOR_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] cap_a_q, cap_b_q;
  cmp_res_t         cap_f_q;

  // Keep only the first failure; err_q low means none recorded yet
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cap_a_q <= '0;
      cap_b_q <= '0;
      cap_f_q <= '0;
    end else if (beat_fail && !err_q) begin
      cap_a_q <= a_q;
      cap_b_q <= b_q;
      cap_f_q <= flg_q;
    end
  end

  assign fail_a     = cap_a_q;
  assign fail_b     = cap_b_q;
  assign fail_flags = cap_f_q;
`endif

  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign err        = err_q;
  assign onehot_err = oh_err_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_comparator_checker.sv
// Bench for comparator_checker. Three instances share clk/rst_n:
//   0: HALT_ON_FAIL=1, CNT_W=16   1: HALT_ON_FAIL=0, CNT_W=16
//   2: HALT_ON_FAIL=1, CNT_W=4
// Accepted beats are pushed to a per-instance queue with their expected
// verdict and popped one cycle later into a behavioural status model.
module tb_comparator_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       vld, clr, rdy, er, oh, hl;
  logic [2:0][1:0]  av, bv;
  logic [2:0][2:0]  fl;
  logic [2:0][15:0] pc, fc;
`ifdef COMPARATOR_CHECKER_CAPTURE_EN
  logic [2:0][1:0]  fa, fb;
  logic [2:0][2:0]  ff;
`endif

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int HOF = (k == 1) ? 0 : 1;
    localparam int CW  = (k == 2) ? 4 : 16;
    logic [CW-1:0] pcw, fcw;
    comparator_checker #(.WIDTH(2), .CNT_W(CW), .HALT_ON_FAIL(HOF)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_a      (av[k]),
      .in_b      (bv[k]),
      .in_equal  (fl[k][2]),
      .in_greater(fl[k][1]),
      .in_less   (fl[k][0]),
      .clear     (clr[k]),
      .pass_cnt  (pcw),
      .fail_cnt  (fcw),
      .err       (er[k]),
      .onehot_err(oh[k]),
`ifdef COMPARATOR_CHECKER_CAPTURE_EN
      .fail_a    (fa[k]),
      .fail_b    (fb[k]),
      .fail_flags(ff[k]),
`endif
      .halted    (hl[k])
    );
    assign pc[k] = 16'(pcw);
    assign fc[k] = 16'(fcw);
  end

  typedef struct {
    logic [1:0] a, b;
    logic [2:0] f;
    bit         pass, oh;
  } beat_t;

  beat_t       sq[3][$];
  int unsigned mp[3], mf[3], maxc[3];
  bit          merr[3], mone[3], mhalt[3], hof[3], pend[3], acc[3];
  logic [1:0]  ca[3], cb[3];
  logic [2:0]  cf[3];
  int          nvec = 0, nerr = 0;

  function automatic logic [2:0] good(input logic [1:0] a, input logic [1:0] b);
    return {a == b, a > b, a < b};
  endfunction

  // One clock: sample handshakes before the edge, advance the model after it
  task automatic step();
    beat_t e;
    #1;
    for (int k = 0; k < 3; k++) acc[k] = vld[k] && rdy[k];
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clr[k]) begin
        mp[k] = 0; mf[k] = 0; merr[k] = 0; mone[k] = 0; mhalt[k] = 0;
        ca[k] = 0; cb[k] = 0; cf[k] = 0; pend[k] = 0;
        sq[k].delete();
      end else begin
        if (pend[k] && sq[k].size() > 0) begin
          e = sq[k].pop_front();
          if (e.pass) begin
            if (mp[k] < maxc[k]) mp[k]++;
          end else begin
            if (mf[k] < maxc[k]) mf[k]++;
            if (!merr[k]) begin ca[k] = e.a; cb[k] = e.b; cf[k] = e.f; end
            merr[k] = 1;
            if (hof[k]) mhalt[k] = 1;
          end
          if (!e.oh) mone[k] = 1;
        end
        pend[k] = acc[k];
        if (acc[k]) begin
          e.a = av[k]; e.b = bv[k]; e.f = fl[k];
          e.pass = (fl[k] == good(av[k], bv[k]));
          e.oh   = ($countones(fl[k]) == 1);
          sq[k].push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input int k, input bit v, input logic [1:0] a,
                       input logic [1:0] b, input logic [2:0] f);
    vld[k] = v; av[k] = a; bv[k] = b; fl[k] = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({pc[k], fc[k]} !== 32'd0 || {er[k], oh[k], hl[k]} !== 3'b000 || rdy[k] !== 1'b1) begin
        nerr++;
        $display("FAIL reset[%0d] got pc=%0d fc=%0d err=%b oh=%b halt=%b rdy=%b want 0 0 0 0 0 1",
                 k, pc[k], fc[k], er[k], oh[k], hl[k], rdy[k]);
      end
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        drive(0, 1'b1, 2'(a), 2'(b), good(2'(a), 2'(b)));
        #1; nvec++;
        if (rdy[0] !== 1'b1) begin
          nerr++; $display("FAIL sweep_ready a=%0d b=%0d got %b want 1", a, b, rdy[0]);
        end
        step();
      end
    drive(0, 1'b0, 0, 0, 0);
    step();
    nvec++;
    if (pc[0] !== 16'd16 || fc[0] !== 16'd0 || er[0] !== 1'b0) begin
      nerr++; $display("FAIL sweep_counts got pc=%0d fc=%0d err=%b want 16 0 0", pc[0], fc[0], er[0]);
    end
  endtask

  task automatic pulse_clear(input int k);
    clr[k] = 1'b1; step(); clr[k] = 1'b0;
  endtask

  task automatic test_halt();
    pulse_clear(0);
    drive(0, 1'b1, 2'd2, 2'd1, 3'b100); step();        // accepted at t
    drive(0, 1'b1, 2'd1, 2'd1, 3'b100);
    #1; nvec++;
    if (rdy[0] !== 1'b1) begin nerr++; $display("FAIL halt_t1_ready got %b want 1", rdy[0]); end
    step();                                            // t+1: still accepted
    drive(0, 1'b1, 2'd0, 2'd3, 3'b001);                // offered while halted
    #1; nvec++;
    if (hl[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      nerr++; $display("FAIL halt_t2 got halted=%b rdy=%b want 1 0", hl[0], rdy[0]);
    end
    step(); step(); step();
    drive(0, 1'b0, 0, 0, 0);
    nvec++;
    if (fc[0] !== 16'd1 || pc[0] !== 16'd1 || er[0] !== 1'b1 || hl[0] !== 1'b1) begin
      nerr++; $display("FAIL halt_counts got pc=%0d fc=%0d err=%b halted=%b want 1 1 1 1",
                       pc[0], fc[0], er[0], hl[0]);
    end
`ifdef COMPARATOR_CHECKER_CAPTURE_EN
    nvec++;
    if (fa[0] !== 2'd2 || fb[0] !== 2'd1 || ff[0] !== 3'b100) begin
      nerr++; $display("FAIL halt_capture got a=%0d b=%0d f=%b want 2 1 100", fa[0], fb[0], ff[0]);
    end
`endif
  endtask

  // Halt with a correct beat still in stage 2, then kill it with clear or reset
  task automatic test_clear_pending(input bit use_rst);
    pulse_clear(0);
    drive(0, 1'b1, 2'd0, 2'd1, 3'b100); step();
    drive(0, 1'b1, 2'd3, 2'd3, 3'b100); step();
    drive(0, 1'b0, 0, 0, 0);
    if (use_rst) rst_n = 1'b0; else clr[0] = 1'b1;
    step();
    rst_n = 1'b1; clr[0] = 1'b0;
    #1; nvec++;
    if ({pc[0], fc[0]} !== 32'd0 || {er[0], oh[0], hl[0]} !== 3'b000 || rdy[0] !== 1'b1) begin
      nerr++; $display("FAIL clear_pending(rst=%0d) got pc=%0d fc=%0d err=%b oh=%b halt=%b rdy=%b want 0 0 0 0 0 1",
                       use_rst, pc[0], fc[0], er[0], oh[0], hl[0], rdy[0]);
    end
    step(); nvec++;
    if (pc[0] !== 16'd0) begin nerr++; $display("FAIL clear_late(rst=%0d) pc=%0d want 0", use_rst, pc[0]); end
`ifdef COMPARATOR_CHECKER_CAPTURE_EN
    nvec++;
    if (fa[0] !== 2'd0 || fb[0] !== 2'd0 || ff[0] !== 3'b000) begin
      nerr++; $display("FAIL clear_capture got a=%0d b=%0d f=%b want 0 0 000", fa[0], fb[0], ff[0]);
    end
`endif
  endtask

  task automatic test_onehot();
    drive(1, 1'b1, 2'd3, 2'd3, 3'b110); step();
    for (int i = 0; i < 10; i++) begin
      logic [1:0] a, b;
      a = 2'($urandom_range(3)); b = 2'($urandom_range(3));
      drive(1, 1'b1, a, b, good(a, b)); step();
    end
    drive(1, 1'b0, 0, 0, 0); step();
    nvec++;
    if (oh[1] !== 1'b1 || fc[1] !== 16'd1 || pc[1] !== 16'd10 || hl[1] !== 1'b0) begin
      nerr++; $display("FAIL onehot got oh=%b fc=%0d pc=%0d halted=%b want 1 1 10 0",
                       oh[1], fc[1], pc[1], hl[1]);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      drive(2, 1'b1, 2'(i), 2'(i >> 2), good(2'(i), 2'(i >> 2)));
      step(); nvec++;
      if (pc[2] !== 16'(mp[2])) begin
        nerr++; $display("FAIL sat_step%0d pc got %0d want %0d", i, pc[2], mp[2]);
      end
    end
    drive(2, 1'b0, 0, 0, 0); step(); step();
    nvec++;
    if (pc[2] !== 16'd15 || fc[2] !== 16'd0) begin
      nerr++; $display("FAIL sat_final got pc=%0d fc=%0d want 15 0", pc[2], fc[2]);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear(1);
    for (int i = 0; i < 300; i++) begin
      logic [1:0] a, b;
      logic [2:0] f;
      a = 2'($urandom_range(3)); b = 2'($urandom_range(3));
      f = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : good(a, b);
      drive(1, ($urandom_range(3) != 0), a, b, f);
      clr[1] = ($urandom_range(40) == 0);
      #1; nvec++;
      if (rdy[1] !== (!mhalt[1] && !clr[1])) begin
        nerr++; $display("FAIL b2b_ready cyc%0d got %b want %b", i, rdy[1], !mhalt[1] && !clr[1]);
      end
      step(); nvec++;
      if (pc[1] !== 16'(mp[1]) || fc[1] !== 16'(mf[1]) || er[1] !== merr[1] || oh[1] !== mone[1]) begin
        nerr++; $display("FAIL b2b cyc%0d got pc=%0d fc=%0d err=%b oh=%b want %0d %0d %b %b",
                         i, pc[1], fc[1], er[1], oh[1], mp[1], mf[1], merr[1], mone[1]);
      end
    end
    clr[1] = 1'b0;
    drive(1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      hof[k]  = (k != 1);
      maxc[k] = (k == 2) ? 15 : 65535;
      mp[k] = 0; mf[k] = 0; pend[k] = 0;
    end
    vld = '0; clr = '0; av = '0; bv = '0; fl = '0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_halt();
    test_clear_pending(1'b0);
    test_clear_pending(1'b1);
    test_onehot();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
